// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide engine with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix-up at the end.
module muldiv_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dzero_q, dzero_d;

  logic               is_signed, a_neg, b_neg, b_is_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum, rem_sh, sub_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  // Operand magnitudes; the accumulator always works on unsigned values.
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign b_is_zero = (b == '0);

  // acc = {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
  assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign sub_diff = rem_sh - {1'b0, opb_q};
  assign prod     = neg_q ? -acc_q : acc_q;
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dzero_q <= dzero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dzero_d = dzero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = {{WIDTH{1'b0}}, a_mag};
          opb_d   = b_mag;
          op_d    = op;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = op[1] & b_is_zero;
          dzero_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CW'(WIDTH - 1);
          state_d = (op[1] && b_is_zero) ? FIX : RUN;
        end else begin
          if (wr_hi) hi_d = a;
          if (wr_lo) lo_d = a;
        end
      end
      RUN: begin
        if (op_q[1]) begin
          // Restoring step: keep the subtraction only when it did not borrow.
          if (!sub_diff[WIDTH]) acc_d = {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        if (dz_q) begin
          dzero_d = 1'b1;
        end else if (op_q[1]) begin
          lo_d = neg_q  ? -quo : quo;
          hi_d = rneg_q ? -rem : rem;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dzero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboarded bench for muldiv_hilo_unit: directed cases plus randomized ops
// against a 64-bit arithmetic reference model.
module tb_muldiv_hilo_unit;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset, start, wr_hi, wr_lo;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int unsigned  at;
  } exp_t;

  exp_t         sb[$];
  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;
  int unsigned  cyc      = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] prev_hi = '0, prev_lo = '0;

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic, returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0]     res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b00: res = 64'(sx * sy);
      2'b01: res = ux * uy;
      2'b10: begin sq = sx / sy; sr = sx % sy; res = {sr[31:0], sq[31:0]}; end
      default: begin uq = ux / uy; ur = ux % uy; res = {ur[31:0], uq[31:0]}; end
    endcase
    return res;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial forever begin
    @(posedge clock);
    #1;
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("div_zero", div_zero, e.dz);
        check("done_cycle", cyc, e.at);
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  // Called at a negedge with the unit idle; returns at the negedge after the start edge.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit with_wr, output int unsigned lat);
    exp_t e;
    bit   dz;
    dz      = o[1] && (y == '0);
    lat     = dz ? 1 : W + 1;
    prev_hi = m_hi;
    prev_lo = m_lo;
    if (!dz) {m_hi, m_lo} = model(o, x, y);
    e.hi = m_hi;
    e.lo = m_lo;
    e.dz = dz;
    e.at = cyc + 1 + lat;
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y; wr_hi = with_wr; wr_lo = with_wr;
    @(negedge clock);
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; a = $urandom; b = $urandom;
    check("dz_clear", div_zero, 1'b0);
    check("busy_on", busy, 1'b1);
  endtask

  // Counts busy negedges from now and checks hi/lo stay put while busy.
  task automatic wait_idle(input int unsigned exp_busy);
    int unsigned n = 0;
    int unsigned hold_err = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (hi !== prev_hi || lo !== prev_lo) hold_err++;
      @(negedge clock);
    end
    if (n >= 200) check("timeout", 64'd1, 64'd0);
    check("busy_cycles", n, exp_busy);
    check("hold", hold_err, 0);
  endtask

  task automatic write_hl(input bit h, input bit l, input logic [W-1:0] v);
    wr_hi = h; wr_lo = l; a = v;
    if (h) m_hi = v;
    if (l) m_lo = v;
    @(negedge clock);
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("wr_hi_val", hi, m_hi);
    check("wr_lo_val", lo, m_lo);
    check("wr_busy", busy, 1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners [5];
    corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int unsigned lat;
    reset = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dz", div_zero, 1'b0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);

    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, lat); wait_idle(lat);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat); wait_idle(lat);
    do_op(2'b11, 32'h0000_0064, 32'h0000_0007, 1'b0, lat); wait_idle(lat);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, lat); wait_idle(lat);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat); wait_idle(lat);

    @(negedge clock);
    write_hl(1'b1, 1'b0, 32'h1234_5678);
    write_hl(1'b0, 1'b1, 32'h9ABC_DEF0);
    do_op(2'b10, 32'h0000_0005, 32'h0000_0000, 1'b0, lat); wait_idle(lat);
    check("dz_held", div_zero, 1'b1);
    write_hl(1'b1, 1'b1, 32'h0BAD_F00D);
    check("dz_held_wr", div_zero, 1'b1);

    // start with mthi/mtlo in IDLE: the writes must be dropped.
    do_op(2'b01, 32'h0000_0002, 32'h0000_0003, 1'b1, lat);
    repeat (9) @(negedge clock);
    start = 1'b1; op = 2'b11; a = 32'hDEAD_BEEF; b = 32'h0000_0003; wr_hi = 1'b1; wr_lo = 1'b1;
    @(negedge clock);
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    wait_idle(W + 1 - 10);

    // Reset in the middle of a multiply aborts it with no done.
    do_op(2'b00, 32'h0000_0007, 32'h0000_0009, 1'b0, lat);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    check("abort_done", done, 1'b0);
    sb.delete();
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("abort_idle", busy, 1'b0);
    do_op(2'b00, 32'h0000_0004, 32'h0000_0005, 1'b0, lat); wait_idle(lat);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        write_hl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end else begin
        logic [W-1:0] x, y;
        x = pick();
        y = ($urandom_range(0, 7) == 0) ? '0 : pick();
        do_op(2'($urandom_range(0, 3)), x, y, 1'b0, lat);
        wait_idle(lat);
      end
    end

    repeat (3) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Parametrised sequential multiply/divide unit with its own HI/LO result registers, for the multicycle CPU datapath.
- Replaces the plain hi/lo holding registers with an iterative engine.
- Supports signed and unsigned multiply, signed and unsigned divide, and direct HI/LO writes (mthi/mtlo).
- The control FSM starts an operation, stalls on busy, and reads hi/lo after done.

Parameters:
WIDTH, 32, operand width and HI/LO register width (>=4)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  begin operation selected by op; sampled only in IDLE
op  input  2  00 mult signed, 01 multu, 10 div signed, 11 divu
a  input  WIDTH  multiplicand / dividend, sampled with start
b  input  WIDTH  multiplier / divisor, sampled with start
wr_hi  input  1  mthi: load hi from a; honoured only in IDLE
wr_lo  input  1  mtlo: load lo from a; honoured only in IDLE
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse, high in the cycle hi/lo become valid
div_zero  output  1  high with done when a divide had b==0; held until the next accepted start
hi  output  WIDTH  HI register (mult: upper product; div: remainder)
lo  output  WIDTH  LO register (mult: lower product; div: quotient)

Behaviour:
- Reset (async, any state): state=IDLE; hi, lo, busy, done, div_zero all 0; iteration counter 0.
- States:
  - IDLE: accepts start, wr_hi, wr_lo.
  - RUN: WIDTH iterations, one per cycle.
  - FIX: sign correction and write-back; done asserted.
  - Then return to IDLE.
- Start, accepted at edge E0 in IDLE with start=1:
  - latch |a| and |b| (magnitudes for signed ops, raw values for unsigned ops), result signs, and op.
  - clear div_zero; busy=1 after E0.
- RUN (edges E1..E_WIDTH):
  - mult: shift-add over a 2*WIDTH accumulator.
  - div: restoring shift-subtract, 1 quotient bit per edge.
  - The counter counts WIDTH-1 down to 0.
- FIX, at edge E_(WIDTH+1):
  - write hi/lo; pulse done=1 for exactly one cycle; busy=0; next state IDLE.
  - Latency from the start edge to done = WIDTH+1 cycles.
- Signed mult: the 2*WIDTH product is negated when the operand signs differ. hi = upper WIDTH bits, lo = lower WIDTH bits.
- Signed div:
  - quotient truncates toward zero, and is negated when the signs differ;
  - the remainder takes the sign of the dividend.
  - MIN / -1 gives lo=MIN, hi=0 with no flag.
- Divide by zero (op[1]=1, b==0 at start):
  - skip RUN; FIX occurs at E1 (done after 1 cycle);
  - hi/lo unchanged; div_zero=1.
- start with busy=1: ignored, no effect on the running operation.
- wr_hi/wr_lo while busy: ignored.
- wr_hi/wr_lo in IDLE: the register takes a at the edge; no done pulse; may assert together.
- start together with wr_hi/wr_lo in IDLE: start wins; the writes are dropped.
- hi/lo hold their previous values throughout RUN; they change only at FIX, on wr_hi/wr_lo, or on reset.
- Reset mid-RUN: operation aborted, no done pulse, registers zeroed.
- Back-to-back: start may be asserted in the cycle done is high (state is IDLE then). It is accepted at the next edge.

Test Plan:
- Reset, then mult signed a=FFFFFFFD (-3), b=00000007 -> done exactly 33 cycles after the start edge; hi=FFFFFFFF, lo=FFFFFFEB; busy high for 33 cycles; div_zero=0.
- multu a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then divu a=00000064, b=00000007 -> lo=0000000E, hi=00000002.
- div signed a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1). Then a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
- wr_hi a=12345678, then wr_lo a=9ABCDEF0 -> hi=12345678, lo=9ABCDEF0, no done. Then div a=5, b=0 -> done 1 cycle after start, div_zero=1, hi/lo unchanged. The next start clears div_zero.
- Start mult 2x3, pulse start (op=divu) and wr_hi at cycle 10 -> both ignored; hi=0, lo=6 at cycle 33.
- Start mult, assert reset at cycle 15 -> immediately busy=0, hi=lo=0; no done pulse ever appears. After release, a new mult 4x5 -> lo=00000014.
